// File: rtl/wb_pdm_fader.sv
// wb_pdm_fader: Wishbone-programmed fade scheduler in front of a PDM block.
// Each channel's level steps toward its programmed target on prescaler ticks;
// changed levels are pushed out through a pipelined Wishbone master, one write
// at a time, round-robin over channels with pending updates.
// Optional feature macro: PDM_FADER_INSTANT_EN (target writes apply at once,
// prescaler removed, register 0xF reads 0).
`timescale 1ns/1ps
module wb_pdm_fader #(
  parameter int unsigned BIT_RESOLUTION  = 8,
  parameter int unsigned CHANNEL_NUM     = 4,
  parameter int unsigned PRESCALER_WIDTH = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        pdm_cyc_o,
  output logic        pdm_stb_o,
  output logic        pdm_we_o,
  output logic [3:0]  pdm_adr_o,
  output logic [31:0] pdm_dat_o,
  input  logic        pdm_stall_i,
  input  logic        pdm_ack_i
);
  localparam logic [3:0] ADR_STATUS = 4'hE;
  localparam logic [3:0] ADR_RELOAD = 4'hF;
  localparam logic [3:0] LAST_CHAN  = 4'(CHANNEL_NUM - 1);
  localparam logic [BIT_RESOLUTION-1:0] LVL_ONE = BIT_RESOLUTION'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;
  logic [BIT_RESOLUTION-1:0] cur [CHANNEL_NUM];
  logic [BIT_RESOLUTION-1:0] tgt [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] dirty, step, wr_chan, wr_set;
  logic [3:0] grant, pick;
  logic pick_valid, tick, slv_req, slv_wr, accept, busy;
  logic [BIT_RESOLUTION-1:0] wr_level, grant_level;
  logic [31:0] rdata, reload_rd;
  int unsigned cand;
  logic unused_bits;

  assign slv_req     = wb_cyc_i & wb_stb_i;
  assign slv_wr      = slv_req & wb_we_i;
  assign wr_level    = wb_dat_i[BIT_RESOLUTION-1:0];
  assign accept      = (state == REQ) & ~pdm_stall_i;
  assign wb_stall_o  = 1'b0;
  assign unused_bits = ^wb_dat_i;

`ifdef PDM_FADER_INSTANT_EN
  assign tick      = 1'b0;
  assign reload_rd = '0;
`else
  logic [PRESCALER_WIDTH-1:0] reload, count;

  // Down-counting tick prescaler; a reload write also restarts the count.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      reload <= '0;
      count  <= '0;
    end else if (slv_wr && wb_adr_i == ADR_RELOAD) begin
      reload <= wb_dat_i[PRESCALER_WIDTH-1:0];
      count  <= wb_dat_i[PRESCALER_WIDTH-1:0];
    end else if (count == '0) begin
      count <= reload;
    end else begin
      count <= count - PRESCALER_WIDTH'(1);
    end
  end

  assign tick      = (count == '0);
  assign reload_rd = 32'(reload);
`endif

  // Per-channel step requests, target-write decode and dirty-set sources.
  always_comb begin
    step    = '0;
    wr_chan = '0;
    wr_set  = '0;
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      step[i]    = tick && (cur[i] != tgt[i]);
      wr_chan[i] = slv_wr && (wb_adr_i == 4'(i));
`ifdef PDM_FADER_INSTANT_EN
      wr_set[i]  = wr_chan[i] && (wr_level != cur[i]);
`endif
    end
  end

  // Current/target levels; a ramp step compares against the pre-write target.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
        cur[i] <= '0;
        tgt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
        if (step[i])
          cur[i] <= (cur[i] < tgt[i]) ? cur[i] + LVL_ONE : cur[i] - LVL_ONE;
        if (wr_chan[i]) begin
          tgt[i] <= wr_level;
`ifdef PDM_FADER_INSTANT_EN
          cur[i] <= wr_level;
`endif
        end
      end
    end
  end

  // Dirty bits: a new level change wins over a same-cycle accept clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      dirty <= '1;
    end else begin
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
        if (step[i] || wr_set[i])
          dirty[i] <= 1'b1;
        else if (accept && grant == 4'(i))
          dirty[i] <= 1'b0;
      end
    end
  end

  // Round-robin pick: first dirty channel after the last granted one.
  always_comb begin
    pick       = grant;
    pick_valid = 1'b0;
    cand       = 0;
    for (int unsigned k = 1; k <= CHANNEL_NUM; k++) begin
      cand = (32'(grant) + k) % CHANNEL_NUM;
      for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
        if (!pick_valid && cand == i && dirty[i]) begin
          pick       = 4'(i);
          pick_valid = 1'b1;
        end
      end
    end
  end

  // Granted level, status and slave read-data mux.
  always_comb begin
    grant_level = '0;
    rdata       = '0;
    busy        = (state != IDLE) || (dirty != '0);
    for (int unsigned i = 0; i < CHANNEL_NUM; i++) begin
      if (grant == 4'(i))
        grant_level = cur[i];
      if (wb_adr_i == 4'(i))
        rdata = 32'(cur[i]);
      if (cur[i] != tgt[i])
        busy = 1'b1;
    end
    if (wb_adr_i == ADR_STATUS)
      rdata = {31'b0, busy};
    else if (wb_adr_i == ADR_RELOAD)
      rdata = reload_rd;
  end

  // Master state and grant pointer; the grant doubles as last-granted.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= LAST_CHAN;
    end else begin
      state <= state_next;
      if (state == IDLE && pick_valid)
        grant <= pick;
    end
  end

  // Master next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = REQ;
      REQ:     if (!pdm_stall_i) state_next = WAIT;
      WAIT:    if (pdm_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign pdm_cyc_o = (state != IDLE);
  assign pdm_stb_o = (state == REQ);
  assign pdm_we_o  = pdm_stb_o;
  assign pdm_adr_o = (state == REQ) ? grant : 4'd0;
  assign pdm_dat_o = (state == REQ) ? 32'(grant_level) : 32'd0;

  // Registered slave acknowledge and read data, one cycle after the strobe.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= slv_req;
      if (slv_req)
        wb_dat_o <= rdata;
    end
  end
endmodule

// File: tb/tb_wb_pdm_fader.sv
// tb_wb_pdm_fader: randomized bench for wb_pdm_fader with a behavioural model
// and per-cycle output comparison, plus literal checks on directed scenarios.
`timescale 1ns/1ps
module tb_wb_pdm_fader;
  localparam int CH = 4;
`ifdef PDM_FADER_INSTANT_EN
  localparam bit INSTANT = 1'b1;
`else
  localparam bit INSTANT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] adr = 4'd0;
  logic [31:0] wdat = 32'd0;
  logic [31:0] rdat;
  logic stall_o, ack_o, pcyc, pstb, pwe;
  logic [3:0] padr;
  logic [31:0] pdat;
  logic pstall = 1'b0, pack = 1'b0;

  wb_pdm_fader #(.BIT_RESOLUTION(8), .CHANNEL_NUM(CH), .PRESCALER_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat), .wb_stall_o(stall_o),
    .wb_ack_o(ack_o), .pdm_cyc_o(pcyc), .pdm_stb_o(pstb), .pdm_we_o(pwe),
    .pdm_adr_o(padr), .pdm_dat_o(pdat), .pdm_stall_i(pstall), .pdm_ack_i(pack));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // PDM slave responder: random stalls, random ack while the master waits.
  int unsigned stall_pct = 0, ack_pct = 100;
  always @(posedge clk) begin
    #1;
    pack   = pcyc && !pstb && ($urandom_range(0, 99) < ack_pct);
    pstall = ($urandom_range(0, 99) < stall_pct);
  end

  // Behavioural model: levels, dirty set, tick count and a single in-flight write.
  int m_cur [CH];
  int m_tgt [CH];
  bit m_dirty [CH];
  int m_cnt, m_reload, m_phase, m_chan, m_rdata, m_a, m_base, m_new;
  bit m_ack, m_tick, m_req, m_wr, m_busy, m_found;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_dirty[i] = 1'b1;
      end
      m_cnt = 0; m_reload = 0; m_phase = 0; m_chan = CH - 1;
      m_rdata = 0; m_ack = 1'b0;
    end else begin
      m_req = cyc && stb;
      m_wr  = m_req && we;
      m_a   = int'(adr);
      m_busy = (m_phase != 0);
      for (int i = 0; i < CH; i++)
        if (m_cur[i] != m_tgt[i] || m_dirty[i]) m_busy = 1'b1;
      m_ack = m_req;
      if (m_req) begin
        if (m_a < CH)       m_rdata = m_cur[m_a];
        else if (m_a == 14) m_rdata = m_busy ? 1 : 0;
        else if (m_a == 15) m_rdata = INSTANT ? 0 : m_reload;
        else                m_rdata = 0;
      end
      m_tick = !INSTANT && (m_cnt == 0);
      if (!INSTANT) begin
        if (m_wr && m_a == 15) begin
          m_reload = int'(wdat & 32'hFFFF);
          m_cnt = m_reload;
        end else if (m_tick) m_cnt = m_reload;
        else m_cnt = m_cnt - 1;
      end
      if (m_phase == 1 && !pstall) m_dirty[m_chan] = 1'b0;
      case (m_phase)
        0: begin
          m_found = 1'b0;
          m_base = m_chan;
          for (int k = 1; k <= CH; k++)
            if (!m_found && m_dirty[(m_base + k) % CH]) begin
              m_found = 1'b1;
              m_chan = (m_base + k) % CH;
            end
          if (m_found) m_phase = 1;
        end
        1: if (!pstall) m_phase = 2;
        default: if (pack) m_phase = 0;
      endcase
      for (int i = 0; i < CH; i++)
        if (m_tick && m_cur[i] != m_tgt[i]) begin
          m_cur[i] += (m_cur[i] < m_tgt[i]) ? 1 : -1;
          m_dirty[i] = 1'b1;
        end
      if (m_wr && m_a < CH) begin
        m_new = int'(wdat & 32'hFF);
        m_tgt[m_a] = m_new;
        if (INSTANT && m_cur[m_a] != m_new) begin
          m_cur[m_a] = m_new;
          m_dirty[m_a] = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model; log accepted writes.
  logic [35:0] wq[$];
  logic [38:0] exp_p;
  always @(negedge clk) begin
    exp_p = {m_phase != 0, m_phase == 1, m_phase == 1,
             (m_phase == 1) ? 4'(m_chan) : 4'd0,
             (m_phase == 1) ? 32'(m_cur[m_chan]) : 32'd0};
    chk("pdm_out", 64'({pcyc, pstb, pwe, padr, pdat}), 64'(exp_p));
    chk("wb_out", 64'({ack_o, stall_o, rdat}), 64'({m_ack, 1'b0, 32'(m_rdata)}));
    if (!rst && pstb && !pstall) wq.push_back({padr, pdat});
  end

  function automatic logic [63:0] wq_at(input int i);
    if (i < wq.size()) return 64'(wq[i]);
    return 64'hDEAD_0000_0000;
  endfunction

  task automatic wb_xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("slave_ack", 64'(ack_o), 64'd1);
    q = rdat;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_resync(input string name);
    chk({name, "_count"}, 64'(wq.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk({name, "_write"}, wq_at(i), {28'd0, 4'(i), 32'd0});
  endtask

  logic [31:0] q;
  int n;

  initial begin
    // Reset state and post-reset resync of every channel to 0.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({pcyc, pstb, ack_o, padr, pdat}), 64'd0);
    wq.delete();
    rst = 1'b0;
    wb_xfer(1'b0, 4'hE, 32'd0, q);
    chk("busy_after_reset", 64'(q), 64'd1);
    idle(40);
    check_resync("boot");
    wb_xfer(1'b0, 4'hE, 32'd0, q);
    chk("idle_after_resync", 64'(q), 64'd0);

    // Fast ramp on channel 0.
    wq.delete();
    wb_xfer(1'b1, 4'h0, 32'd3, q);
    idle(30);
    wb_xfer(1'b0, 4'h0, 32'd0, q);
    chk("ch0_level", 64'(q), 64'd3);
    chk("ch0_last_write", (wq.size() > 0) ? 64'(wq[$]) : 64'hDEAD, {28'd0, 4'd0, 32'd3});

    // Slow ramp on channel 1 with reload 9.
    wb_xfer(1'b1, 4'hF, 32'd9, q);
    wb_xfer(1'b1, 4'h1, 32'h80, q);
    idle(1320);
    wb_xfer(1'b0, 4'h1, 32'd0, q);
    chk("ch1_level", 64'(q), 64'h80);
    wb_xfer(1'b0, 4'hE, 32'd0, q);
    chk("ch1_idle", 64'(q), 64'd0);

    // Two channels pending while the PDM side stalls.
    wb_xfer(1'b1, 4'hF, 32'd0, q);
    stall_pct = 100;
    wq.delete();
    wb_xfer(1'b1, 4'h0, 32'd4, q);
    wb_xfer(1'b1, 4'h2, 32'd1, q);
    idle(6);
    chk("stall_hold", 64'({pstb, padr}), 64'({1'b1, 4'd0}));
    stall_pct = 0;
    idle(20);
    chk("stall_count", 64'(wq.size()), 64'd2);
    chk("stall_first", wq_at(0), {28'd0, 4'd0, 32'd4});
    chk("stall_second", wq_at(1), {28'd0, 4'd2, 32'd1});

    // Randomized traffic on both ports.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wb_xfer(1'b1, 4'($urandom_range(0, CH - 1)), $urandom, q);
        4:          wb_xfer(1'b1, 4'hF, ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3), q);
        5, 6:       wb_xfer(1'b0, 4'($urandom_range(0, 15)), $urandom, q);
        7:          wb_xfer(1'b1, 4'($urandom_range(CH, 14)), $urandom, q);
        8:          idle($urandom_range(1, 6));
        default: begin
          stall_pct = $urandom_range(0, 70);
          ack_pct   = $urandom_range(20, 100);
        end
      endcase
    end

    // Reset while waiting for an ack.
    stall_pct = 0;
    ack_pct = 0;
    wb_xfer(1'b1, 4'h3, (m_cur[3] == 8'h55) ? 32'hAA : 32'h55, q);
    n = 0;
    while (!(pcyc && !pstb) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_reached", 64'(pcyc && !pstb), 64'd1);
    rst = 1'b1;
    #1;
    chk("reset_drops_cyc", 64'({pcyc, pstb}), 64'd0);
    idle(2);
    ack_pct = 100;
    wq.delete();
    rst = 1'b0;
    idle(40);
    check_resync("rereset");

`ifdef PDM_FADER_INSTANT_EN
    // Immediate target application.
    wq.delete();
    wb_xfer(1'b1, 4'h3, 32'hFF, q);
    wb_xfer(1'b0, 4'h3, 32'd0, q);
    chk("instant_level", 64'(q), 64'hFF);
    idle(10);
    chk("instant_count", 64'(wq.size()), 64'd1);
    chk("instant_write", wq_at(0), {28'd0, 4'd3, 32'hFF});
    wb_xfer(1'b1, 4'hF, 32'd7, q);
    wb_xfer(1'b0, 4'hF, 32'd0, q);
    chk("instant_reload", 64'(q), 64'd0);
`endif

    idle(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
